// File: rtl/fp_issue_scoreboard.sv
// Issue controller and scoreboard for a single non-pipelined multi-cycle FPU: one op in flight, structural/RAW stalls, wb pulse.
// Optional macro FP_WB_BYPASS_EN: releases RAW stall in WB and exposes fpu_bypass_fs/fpu_bypass_ft.
module fp_issue_scoreboard #(
  parameter int REG_W   = 5,
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_fp_valid,
  input  logic [1:0]       id_fp_op,
  input  logic [REG_W-1:0] id_fs,
  input  logic [REG_W-1:0] id_ft,
  input  logic             id_rd_fs_en,
  input  logic             id_rd_ft_en,
  input  logic [REG_W-1:0] id_fd,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             control_mux_select,
  output logic             fpu_start,
  output logic [1:0]       fpu_op_q,
  output logic [REG_W-1:0] fpu_fd_q,
  output logic             fpu_busy,
  output logic             fpu_wb_en,
  output logic [REG_W-1:0] fpu_wb_reg
`ifdef FP_WB_BYPASS_EN
  ,
  output logic             fpu_bypass_fs,
  output logic             fpu_bypass_ft
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_m1;
  logic             fs_hit, ft_hit;
  logic             stall_struct, stall_raw, stall, accept;

  assign fs_hit = id_rd_fs_en && (id_fs == fpu_fd_q);
  assign ft_hit = id_rd_ft_en && (id_ft == fpu_fd_q);

  assign stall_struct = id_fp_valid && (state == EXEC);
`ifdef FP_WB_BYPASS_EN
  // In WB the result is forwarded into ID, so only EXEC needs to hold a dependent.
  assign stall_raw     = (state == EXEC) && (fs_hit || ft_hit);
  assign fpu_bypass_fs = (state == WB) && fs_hit;
  assign fpu_bypass_ft = (state == WB) && ft_hit;
`else
  assign stall_raw = (state != IDLE) && (fs_hit || ft_hit);
`endif
  assign stall  = stall_struct || stall_raw;
  assign accept = id_fp_valid && !stall;

  assign PC_Write           = !stall;
  assign IF_ID_Write        = !stall;
  assign control_mux_select = stall;
  assign fpu_busy           = (state != IDLE);
  assign fpu_wb_en          = (state == WB);
  assign fpu_wb_reg         = fpu_fd_q;

  always_comb begin
    lat_m1 = CNT_W'(ADD_LAT - 1);
    case (id_fp_op)
      2'b10:   lat_m1 = CNT_W'(MUL_LAT - 1);
      2'b11:   lat_m1 = CNT_W'(DIV_LAT - 1);
      default: lat_m1 = CNT_W'(ADD_LAT - 1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fpu_op_q  <= '0;
      fpu_fd_q  <= '0;
      fpu_start <= 1'b0;
    end else begin
      fpu_start <= accept;
      case (state)
        EXEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= WB;
        end
        default: begin
          // IDLE and WB both accept; WB retires the old op on the same edge.
          if (accept) begin
            state    <= EXEC;
            cnt      <= lat_m1;
            fpu_op_q <= id_fp_op;
            fpu_fd_q <= id_fd;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Directed bench for fp_issue_scoreboard: reset, latency, back-to-back issue, RAW stalls, async reset.
module tb_fp_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_fp_valid = 1'b0;
  logic [1:0] id_fp_op = 2'b00;
  logic [4:0] id_fs = '0, id_ft = '0, id_fd = '0;
  logic       id_rd_fs_en = 1'b0, id_rd_ft_en = 1'b0;
  logic       PC_Write, IF_ID_Write, control_mux_select;
  logic       fpu_start, fpu_busy, fpu_wb_en;
  logic [1:0] fpu_op_q;
  logic [4:0] fpu_fd_q, fpu_wb_reg;
`ifdef FP_WB_BYPASS_EN
  logic       fpu_bypass_fs, fpu_bypass_ft;
`endif

  int checks = 0;
  int errors = 0;

  fp_issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .id_fp_valid(id_fp_valid), .id_fp_op(id_fp_op),
    .id_fs(id_fs), .id_ft(id_ft),
    .id_rd_fs_en(id_rd_fs_en), .id_rd_ft_en(id_rd_ft_en),
    .id_fd(id_fd),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .control_mux_select(control_mux_select),
    .fpu_start(fpu_start), .fpu_op_q(fpu_op_q), .fpu_fd_q(fpu_fd_q),
    .fpu_busy(fpu_busy), .fpu_wb_en(fpu_wb_en), .fpu_wb_reg(fpu_wb_reg)
`ifdef FP_WB_BYPASS_EN
    , .fpu_bypass_fs(fpu_bypass_fs), .fpu_bypass_ft(fpu_bypass_ft)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; callers drive inputs, then wait #1 and sample.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_fp_valid = 1'b0;
    id_rd_fs_en = 1'b0;
    id_rd_ft_en = 1'b0;
    id_fs = '0; id_ft = '0; id_fd = '0; id_fp_op = 2'b00;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft);
    id_fp_valid = 1'b1; id_fp_op = op; id_fd = fd; id_fs = fs; id_ft = ft;
    id_rd_fs_en = 1'b1; id_rd_ft_en = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (fpu_busy !== 1'b0 || fpu_wb_en !== 1'b0 || fpu_start !== 1'b0 || fpu_fd_q !== 5'd0 || fpu_op_q !== 2'd0)
      $display("FAIL reset_regs busy=%b wb=%b start=%b fd=%0d op=%0d want 0s", fpu_busy, fpu_wb_en, fpu_start, fpu_fd_q, fpu_op_q);
    cyc(); cyc();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      cyc(); #1;
      checks++;
      if (PC_Write !== 1'b1 || IF_ID_Write !== 1'b1 || control_mux_select !== 1'b0 || fpu_busy !== 1'b0 || fpu_wb_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle t=%0d pc=%b ifid=%b mux=%b busy=%b wb=%b want 1 1 0 0 0", t, PC_Write, IF_ID_Write, control_mux_select, fpu_busy, fpu_wb_en);
      end
    end
  endtask

  task automatic test_add_latency();
    cyc(); issue(2'b00, 5'd3, 5'd1, 5'd2); #1;
    checks++;
    if (PC_Write !== 1'b1 || control_mux_select !== 1'b0) begin
      errors++; $display("FAIL add_accept pc=%b mux=%b want 1 0", PC_Write, control_mux_select);
    end
    for (int t = 1; t <= 5; t++) begin
      cyc(); idle_inputs(); #1;
      checks++;
      if (fpu_start !== (t == 1)) begin
        errors++; $display("FAIL add_start t=%0d got %b want %b", t, fpu_start, (t == 1));
      end
      checks++;
      if (fpu_wb_en !== (t == 4)) begin
        errors++; $display("FAIL add_wb_en t=%0d got %b want %b", t, fpu_wb_en, (t == 4));
      end
      if (t == 4) begin
        checks++;
        if (fpu_wb_reg !== 5'd3) begin
          errors++; $display("FAIL add_wb_reg got %0d want 3", fpu_wb_reg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(); issue(2'b11, 5'd5, 5'd1, 5'd2); #1;
    checks++;
    if (PC_Write !== 1'b1) begin
      errors++; $display("FAIL b2b_div_accept pc=%b want 1", PC_Write);
    end
    for (int t = 1; t <= 17; t++) begin
      cyc();
      if (t <= 11) issue(2'b10, 5'd6, 5'd8, 5'd9);
      else         idle_inputs();
      #1;
      checks++;
      if (control_mux_select !== (t <= 10) || PC_Write !== !(t <= 10)) begin
        errors++; $display("FAIL b2b_stall t=%0d mux=%b pc=%b want mux %b", t, control_mux_select, PC_Write, (t <= 10));
      end
      checks++;
      if (fpu_wb_en !== (t == 11 || t == 16)) begin
        errors++; $display("FAIL b2b_wb_en t=%0d got %b want %b", t, fpu_wb_en, (t == 11 || t == 16));
      end
      checks++;
      if (fpu_start !== (t == 1 || t == 12)) begin
        errors++; $display("FAIL b2b_start t=%0d got %b want %b", t, fpu_start, (t == 1 || t == 12));
      end
      if (t == 11) begin
        checks++;
        if (fpu_wb_reg !== 5'd5) begin
          errors++; $display("FAIL b2b_wb_reg_div got %0d want 5", fpu_wb_reg);
        end
      end
      if (t == 12) begin
        checks++;
        if (fpu_op_q !== 2'b10 || fpu_fd_q !== 5'd6) begin
          errors++; $display("FAIL b2b_latch op=%0d fd=%0d want 2 6", fpu_op_q, fpu_fd_q);
        end
      end
      if (t == 16) begin
        checks++;
        if (fpu_wb_reg !== 5'd6) begin
          errors++; $display("FAIL b2b_wb_reg_mul got %0d want 6", fpu_wb_reg);
        end
      end
    end
    checks++;
    if (fpu_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle busy=%b want 0", fpu_busy);
    end
  endtask

  task automatic test_raw();
    logic exp_stall;
    cyc(); issue(2'b00, 5'd7, 5'd1, 5'd2); #1;
    for (int t = 1; t <= 5; t++) begin
      cyc();
      idle_inputs();
      id_rd_fs_en = 1'b1; id_fs = 5'd7;
      #1;
`ifdef FP_WB_BYPASS_EN
      exp_stall = (t <= 3);
      if (t == 4) begin
        checks++;
        if (fpu_bypass_fs !== 1'b1 || fpu_bypass_ft !== 1'b0) begin
          errors++; $display("FAIL raw_bypass fs=%b ft=%b want 1 0", fpu_bypass_fs, fpu_bypass_ft);
        end
      end
`else
      exp_stall = (t <= 4);
`endif
      checks++;
      if (control_mux_select !== exp_stall || IF_ID_Write !== !exp_stall) begin
        errors++; $display("FAIL raw_stall t=%0d mux=%b ifid=%b want mux %b", t, control_mux_select, IF_ID_Write, exp_stall);
      end
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_reset_mid_exec();
    cyc(); issue(2'b11, 5'd5, 5'd1, 5'd2); #1;
    for (int t = 1; t <= 4; t++) begin
      cyc(); issue(2'b10, 5'd6, 5'd5, 5'd5); #1;
    end
    checks++;
    if (control_mux_select !== 1'b1 || fpu_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre mux=%b busy=%b want 1 1", control_mux_select, fpu_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (fpu_busy !== 1'b0 || PC_Write !== 1'b1 || control_mux_select !== 1'b0 || fpu_wb_en !== 1'b0 || fpu_fd_q !== 5'd0) begin
      errors++; $display("FAIL rst_async busy=%b pc=%b mux=%b wb=%b fd=%0d want 0 1 0 0 0", fpu_busy, PC_Write, control_mux_select, fpu_wb_en, fpu_fd_q);
    end
    idle_inputs();
    cyc();
    reset = 1'b0;
    for (int t = 0; t < 12; t++) begin
      cyc(); #1;
      checks++;
      if (fpu_wb_en !== 1'b0 || fpu_busy !== 1'b0) begin
        errors++; $display("FAIL rst_no_wb t=%0d wb=%b busy=%b want 0 0", t, fpu_wb_en, fpu_busy);
      end
    end
  endtask

  task automatic test_no_false_raw();
    cyc(); issue(2'b01, 5'd7, 5'd1, 5'd2); #1;
    for (int t = 1; t <= 3; t++) begin
      cyc(); idle_inputs();
      case (t)
        1: begin id_rd_fs_en = 1'b1; id_fs = 5'd9; id_ft = 5'd7; end
        2: begin id_fs = 5'd7; id_ft = 5'd7; end
        default: begin id_rd_ft_en = 1'b1; id_ft = 5'd9; id_fs = 5'd7; end
      endcase
      #1;
      checks++;
      if (control_mux_select !== 1'b0 || PC_Write !== 1'b1) begin
        errors++; $display("FAIL no_raw t=%0d mux=%b pc=%b want 0 1", t, control_mux_select, PC_Write);
      end
    end
    for (int t = 0; t < 3; t++) begin
      cyc(); idle_inputs();
    end
    checks++;
    if (fpu_busy !== 1'b0) begin
      errors++; $display("FAIL no_raw_drain busy=%b want 0", fpu_busy);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_raw();
    test_reset_mid_exec();
    test_no_false_raw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
